// File: rtl/dvp_capture_ctrl.sv
// DVP capture sequencer: skips start-up frames, arms on a frame boundary,
// gates capture per frame and checks each captured frame's geometry.
module dvp_capture_ctrl #(
   parameter int unsigned SKIP_FRAMES = 10,
   parameter int unsigned H_ACTIVE    = 1280,
   parameter int unsigned V_ACTIVE    = 720
) (
   input  logic        PCLK,
   input  logic        Rst_n,
   input  logic        Vsync,
   input  logic        Href,
   input  logic        cap_start,
   input  logic        cap_stop,
   input  logic        cap_mode,
   output logic        cap_en,
   output logic        busy,
   output logic        frame_done,
   output logic        geom_err,
   output logic [15:0] frame_cnt,
   output logic [11:0] last_pix,
   output logic [10:0] last_lines,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SKIP    = 3'd1,
      ARM     = 3'd2,
      CAPTURE = 3'd3
   } state_e;

   state_e      state_q, state_d;
   logic        vsync_q, href_q;
   logic        cap_en_q, cap_en_d;
   logic        busy_q, busy_d;
   logic        frame_done_q, frame_done_d;
   logic        geom_err_q, geom_err_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [11:0] last_pix_q, last_pix_d;
   logic [10:0] last_lines_q, last_lines_d;
   logic [11:0] pix_cnt_q, pix_cnt_d;
   logic [10:0] line_cnt_q, line_cnt_d;
   logic [7:0]  skip_cnt_q, skip_cnt_d;
   logic        line_err_q, line_err_d;
   logic        stop_pend_q, stop_pend_d;
   logic        mode_q, mode_d;

   logic        vs_rise, vs_fall, line_end, start_ok;
   logic [7:0]  skip_inc;
   logic [10:0] lines_tot;
   logic        line_bad;

   assign vs_rise  = Vsync & ~vsync_q;
   assign vs_fall  = ~Vsync & vsync_q;
   assign line_end = href_q & ~Href;
   assign start_ok = cap_start & ~cap_stop;
   assign skip_inc = skip_cnt_q + 8'd1;
   // A line closing on the frame-ending edge still belongs to this frame.
   assign lines_tot = (line_end && line_cnt_q != '1) ? line_cnt_q + 11'd1 : line_cnt_q;
   assign line_bad  = line_end & (pix_cnt_q != 12'(H_ACTIVE));

   always_ff @(posedge PCLK or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q      <= IDLE;
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         cap_en_q     <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         geom_err_q   <= 1'b0;
         frame_cnt_q  <= '0;
         last_pix_q   <= '0;
         last_lines_q <= '0;
         pix_cnt_q    <= '0;
         line_cnt_q   <= '0;
         skip_cnt_q   <= '0;
         line_err_q   <= 1'b0;
         stop_pend_q  <= 1'b0;
         mode_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         vsync_q      <= Vsync;
         href_q       <= Href;
         cap_en_q     <= cap_en_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         geom_err_q   <= geom_err_d;
         frame_cnt_q  <= frame_cnt_d;
         last_pix_q   <= last_pix_d;
         last_lines_q <= last_lines_d;
         pix_cnt_q    <= pix_cnt_d;
         line_cnt_q   <= line_cnt_d;
         skip_cnt_q   <= skip_cnt_d;
         line_err_q   <= line_err_d;
         stop_pend_q  <= stop_pend_d;
         mode_q       <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = (SKIP_FRAMES == 0) ? ARM : SKIP;
         SKIP: begin
            if (cap_stop)                                       state_d = IDLE;
            else if (vs_rise && skip_inc == 8'(SKIP_FRAMES))    state_d = ARM;
         end
         ARM: begin
            if (cap_stop)     state_d = IDLE;
            else if (vs_fall) state_d = CAPTURE;
         end
         CAPTURE: begin
            // A stop arriving on the frame-ending edge is honoured immediately.
            if (vs_rise) state_d = (mode_q || stop_pend_q || cap_stop) ? IDLE : ARM;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cap_en_d     = cap_en_q;
      busy_d       = (state_d != IDLE);
      frame_done_d = 1'b0;
      geom_err_d   = geom_err_q;
      frame_cnt_d  = frame_cnt_q;
      last_pix_d   = last_pix_q;
      last_lines_d = last_lines_q;
      pix_cnt_d    = pix_cnt_q;
      line_cnt_d   = line_cnt_q;
      skip_cnt_d   = skip_cnt_q;
      line_err_d   = line_err_q;
      stop_pend_d  = stop_pend_q;
      mode_d       = mode_q;
      case (state_q)
         IDLE: begin
            if (start_ok) begin
               mode_d     = cap_mode;
               geom_err_d = 1'b0;
               skip_cnt_d = '0;
            end
         end
         SKIP: begin
            if (!cap_stop && vs_rise) skip_cnt_d = skip_inc;
         end
         ARM: begin
            if (!cap_stop && vs_fall) begin
               cap_en_d   = 1'b1;
               pix_cnt_d  = '0;
               line_cnt_d = '0;
               line_err_d = 1'b0;
            end
         end
         CAPTURE: begin
            if (cap_stop) stop_pend_d = 1'b1;
            if (Href && pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + 12'd1;
            if (line_end) begin
               last_pix_d = pix_cnt_q;
               line_err_d = line_err_q | line_bad;
               line_cnt_d = lines_tot;
               pix_cnt_d  = '0;
            end
            if (vs_rise) begin
               cap_en_d     = 1'b0;
               frame_done_d = 1'b1;
               frame_cnt_d  = frame_cnt_q + 16'd1;
               last_lines_d = lines_tot;
               geom_err_d   = geom_err_q | line_err_q | line_bad |
                              (lines_tot != 11'(V_ACTIVE));
               stop_pend_d  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign cap_en     = cap_en_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign geom_err   = geom_err_q;
   assign frame_cnt  = frame_cnt_q;
   assign last_pix   = last_pix_q;
   assign last_lines = last_lines_q;
   assign state      = state_q;

endmodule
